// File: rtl/piezo_tone_pkg.sv
// Shared note table, state encoding and helpers for the piezo tone generator.
package piezo_tone_pkg;

   localparam int NOTE_COUNT = 13;
   localparam logic [3:0] NOTE_NONE = 4'hF;

   typedef enum logic [1:0] {
      SILENT,
      GAP,
      PLAY
   } tone_state_t;

   // Half-periods in 1 us ticks, C4 through C5 chromatic.
   function automatic logic [10:0] half_period(input logic [3:0] n);
      logic [10:0] hp;
      case (n)
         4'd0:    hp = 11'd1911;
         4'd1:    hp = 11'd1804;
         4'd2:    hp = 11'd1703;
         4'd3:    hp = 11'd1607;
         4'd4:    hp = 11'd1517;
         4'd5:    hp = 11'd1432;
         4'd6:    hp = 11'd1351;
         4'd7:    hp = 11'd1276;
         4'd8:    hp = 11'd1204;
         4'd9:    hp = 11'd1136;
         4'd10:   hp = 11'd1073;
         4'd11:   hp = 11'd1012;
         4'd12:   hp = 11'd956;
         default: hp = 11'd1911;
      endcase
      return hp;
   endfunction

   function automatic logic [3:0] first_set(input logic [12:0] b);
      logic [3:0] r;
      r = NOTE_NONE;
      for (int i = NOTE_COUNT - 1; i >= 0; i--) begin
         if (b[i]) r = 4'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/piezo_tick_div.sv
// Free-running prescaler producing a one-clock tick every PRESCALE clocks.
module piezo_tick_div #(
   parameter int PRESCALE = 50
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clock) begin
      if (!reset)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + W'(1);
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/piezo_tone_gen.sv
// One-hot note to piezo square wave with a silent gap on every note change.
// Optional PIEZO_OCTAVE_UP_EN adds an octave_up input halving the half-period.
module piezo_tone_gen
   import piezo_tone_pkg::*;
#(
   parameter int PRESCALE  = 50,
   parameter int GAP_TICKS = 1000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [12:0] beat,
   input  logic        enable,
`ifdef PIEZO_OCTAVE_UP_EN
   input  logic        octave_up,
`endif
   output logic        piezo,
   output logic        tone_active,
   output logic [3:0]  note_idx
);

   localparam logic [15:0] GAP_LAST =
      (GAP_TICKS > 0) ? 16'(GAP_TICKS - 1) : 16'd0;

   logic [12:0] beat_q;
   logic        en_q;
   logic        tick;
   logic [3:0]  sel;
   logic [10:0] hp_eff;
   logic        changed;
   logic        enter;

   tone_state_t state, state_n;
   logic [3:0]  cur_note, cur_n;
   logic [15:0] gap_cnt, gap_n;
   logic [10:0] hp_cnt, hp_n;
   logic        piezo_n;

   piezo_tick_div #(.PRESCALE(PRESCALE)) u_div (
      .clock (clock),
      .reset (reset),
      .tick  (tick)
   );

   assign sel = first_set(beat_q);

`ifdef PIEZO_OCTAVE_UP_EN
   logic oct_q, oct_cur, oct_n;

   always_ff @(posedge clock) begin
      if (!reset) begin
         oct_q   <= 1'b0;
         oct_cur <= 1'b0;
      end else begin
         oct_q   <= octave_up;
         oct_cur <= oct_n;
      end
   end

   assign hp_eff  = oct_cur ? (half_period(cur_note) >> 1)
                            : half_period(cur_note);
   assign changed = (sel != cur_note) || (oct_q != oct_cur);
`else
   assign hp_eff  = half_period(cur_note);
   assign changed = (sel != cur_note);
`endif

   always_comb begin
      state_n = state;
      cur_n   = cur_note;
      gap_n   = gap_cnt;
      hp_n    = hp_cnt;
      piezo_n = piezo;
      enter   = 1'b0;
`ifdef PIEZO_OCTAVE_UP_EN
      oct_n   = oct_cur;
`endif
      if (!en_q || sel == NOTE_NONE) begin
         state_n = SILENT;
         gap_n   = '0;
         hp_n    = '0;
         piezo_n = 1'b0;
      end else begin
         unique case (state)
            SILENT: enter = 1'b1;
            GAP: begin
               if (changed)
                  enter = 1'b1;
               else if (tick && gap_cnt == GAP_LAST) begin
                  state_n = PLAY;
                  hp_n    = '0;
                  piezo_n = 1'b0;
               end else if (tick)
                  gap_n = gap_cnt + 16'd1;
            end
            PLAY: begin
               if (changed)
                  enter = 1'b1;
               else if (tick && hp_cnt == hp_eff - 11'd1) begin
                  hp_n    = '0;
                  piezo_n = ~piezo;
               end else if (tick)
                  hp_n = hp_cnt + 11'd1;
            end
            default: state_n = SILENT;
         endcase
      end
      // A zero-length gap re-enters PLAY directly with counters cleared.
      if (enter) begin
         cur_n   = sel;
         gap_n   = '0;
         hp_n    = '0;
         piezo_n = 1'b0;
         state_n = (GAP_TICKS == 0) ? PLAY : GAP;
`ifdef PIEZO_OCTAVE_UP_EN
         oct_n   = oct_q;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         beat_q   <= '0;
         en_q     <= 1'b0;
         state    <= SILENT;
         cur_note <= NOTE_NONE;
         gap_cnt  <= '0;
         hp_cnt   <= '0;
         piezo    <= 1'b0;
      end else begin
         beat_q   <= beat;
         en_q     <= enable;
         state    <= state_n;
         cur_note <= cur_n;
         gap_cnt  <= gap_n;
         hp_cnt   <= hp_n;
         piezo    <= piezo_n;
      end
   end

   assign tone_active = (state == PLAY);
   assign note_idx    = (state == SILENT) ? NOTE_NONE : cur_note;

endmodule

// File: tb/tb_piezo_tone_gen.sv
// Directed scoreboard bench for piezo_tone_gen (PRESCALE=1, GAP_TICKS=4).
module tb_piezo_tone_gen;

   localparam int PRESCALE  = 1;
   localparam int GAP_TICKS = 4;
   localparam int BUDGET    = 5000;

   logic        clock;
   logic        reset;
   logic [12:0] beat;
   logic        enable;
`ifdef PIEZO_OCTAVE_UP_EN
   logic        octave_up;
`endif
   logic        piezo;
   logic        tone_active;
   logic [3:0]  note_idx;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   piezo_tone_gen #(
      .PRESCALE  (PRESCALE),
      .GAP_TICKS (GAP_TICKS)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .beat        (beat),
      .enable      (enable),
`ifdef PIEZO_OCTAVE_UP_EN
      .octave_up   (octave_up),
`endif
      .piezo       (piezo),
      .tone_active (tone_active),
      .note_idx    (note_idx)
   );

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
         failed++;
         $error("FAIL sb_empty observed=%0d expected=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      @(negedge clock);
   endtask

   task automatic wait_level(input logic lvl, output int n);
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (piezo !== lvl && n < BUDGET);
   endtask

   task automatic wait_play(output int n, output int bad);
      n   = 0;
      bad = 0;
      while (tone_active !== 1'b1 && n < BUDGET) begin
         if (piezo !== 1'b0) bad++;
         n++;
         cyc(1);
      end
   endtask

   int n, n2, bad;

   initial begin
      reset  = 1'b0;
      beat   = 13'h0200;
      enable = 1'b1;
`ifdef PIEZO_OCTAVE_UP_EN
      octave_up = 1'b0;
`endif
      @(negedge clock);

      for (int i = 0; i < 3; i++) begin
         push("rst_piezo", 0);
         push("rst_note", 4'hF);
         push("rst_tone", 0);
         cyc(1);
         check(piezo);
         check(note_idx);
         check(tone_active);
      end

      // Basic A4 tone
      reset = 1'b1;
      push("a4_lat_note", 4'hF);
      push("a4_note", 9);
      push("a4_gap_tone", 0);
      push("a4_gap_len", GAP_TICKS);
      push("a4_gap_piezo", 0);
      push("a4_play_piezo", 0);
      push("a4_first_rise", 1136);
      push("a4_period", 2272);
      cyc(1);
      check(note_idx);
      cyc(1);
      check(note_idx);
      check(tone_active);
      wait_play(n, bad);
      check(n);
      check(bad);
      check(piezo);
      wait_level(1'b1, n);
      check(n);
      wait_level(1'b0, n);
      wait_level(1'b1, n2);
      check(n + n2);

      // Multi-hot: lowest bit wins (F4)
      beat = 13'h0120;
      push("mh_lat_note", 9);
      push("mh_note", 5);
      push("mh_gap_len", GAP_TICKS);
      push("mh_gap_piezo", 0);
      push("mh_hp_hi", 1432);
      push("mh_hp_lo", 1432);
      cyc(1);
      check(note_idx);
      cyc(1);
      check(note_idx);
      wait_play(n, bad);
      check(n);
      check(bad);
      wait_level(1'b1, n);
      check(n);
      wait_level(1'b0, n);
      check(n);

      // Note change G#4 -> C5 while sounding
      beat = 13'h0100;
      push("chg_first_note", 8);
      cyc(2);
      check(note_idx);
      wait_play(n, bad);
      wait_level(1'b1, n);
      beat = 13'h1000;
      push("chg_lat_tone", 1);
      push("chg_note", 12);
      push("chg_piezo", 0);
      push("chg_gap_len", GAP_TICKS);
      push("chg_gap_piezo", 0);
      push("chg_hp_hi", 956);
      push("chg_hp_lo", 956);
      cyc(1);
      check(tone_active);
      cyc(1);
      check(note_idx);
      check(piezo);
      wait_play(n, bad);
      check(n);
      check(bad);
      wait_level(1'b1, n);
      check(n);
      wait_level(1'b0, n);
      check(n);

      // One-cycle enable drop
      wait_level(1'b1, n);
      enable = 1'b0;
      push("mute_lat_tone", 1);
      push("mute_tone", 0);
      push("mute_piezo", 0);
      push("mute_note", 4'hF);
      push("mute_re_note", 12);
      push("mute_gap_len", GAP_TICKS);
      push("mute_hp", 956);
      cyc(1);
      enable = 1'b1;
      check(tone_active);
      cyc(1);
      check(tone_active);
      check(piezo);
      check(note_idx);
      cyc(1);
      check(note_idx);
      wait_play(n, bad);
      check(n);
      wait_level(1'b1, n);
      check(n);

      // Rest (beat = 0), then D-flat4
      beat = 13'h0000;
      push("rest_note", 4'hF);
      push("rest_piezo", 0);
      push("rest_hold_note", 4'hF);
      push("rest_hold_tone", 0);
      cyc(2);
      check(note_idx);
      check(piezo);
      cyc(5);
      check(note_idx);
      check(tone_active);
      beat = 13'h0002;
      push("db4_note", 1);
      push("db4_gap_len", GAP_TICKS);
      push("db4_hp", 1804);
      cyc(2);
      check(note_idx);
      wait_play(n, bad);
      check(n);
      wait_level(1'b1, n);
      check(n);

      // Reset while sounding
      reset = 1'b0;
      push("rst_mid_piezo", 0);
      push("rst_mid_tone", 0);
      push("rst_mid_note", 4'hF);
      cyc(1);
      check(piezo);
      check(tone_active);
      check(note_idx);
      reset = 1'b1;
      push("post_rst_note", 1);
      push("post_rst_gap", GAP_TICKS);
      cyc(2);
      check(note_idx);
      wait_play(n, bad);
      check(n);

`ifdef PIEZO_OCTAVE_UP_EN
      beat      = 13'h0200;
      octave_up = 1'b1;
      push("oct_note", 9);
      push("oct_gap_len", GAP_TICKS);
      push("oct_hp", 568);
      cyc(2);
      check(note_idx);
      wait_play(n, bad);
      check(n);
      wait_level(1'b1, n);
      check(n);
      octave_up = 1'b0;
      push("oct_chg_tone", 0);
      push("oct_chg_gap", GAP_TICKS);
      push("oct_off_hp", 1136);
      cyc(2);
      check(tone_active);
      wait_play(n, bad);
      check(n);
      wait_level(1'b1, n);
      check(n);
`endif

      if (sb.size() != 0) begin
         tests++;
         failed++;
         $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
